// File: rtl/banked_mem_pkg.sv
// Shared constants and helpers for the banked multi-port scratchpad.
package banked_mem_pkg;

  localparam int DefNumPorts  = 4;
  localparam int DefNumBanks  = 4;
  localparam int DefDataWidth = 8;
  localparam int DefDataDepth = 4096;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping,
// and moves the pointer just past the winner when the grant is consumed.
module rr_arbiter
  import banked_mem_pkg::*;
#(
  parameter int NumReq = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int PtrW = safe_clog2(NumReq);

  logic [PtrW-1:0] rr_q, rr_d;
  logic            found;

  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    gnt_o = '0;
    rr_d  = rr_q;
    found = 1'b0;
    // First pass: indices at or above the pointer; second pass wraps to the bottom.
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_i[i] && (PtrW'(i) >= rr_q)) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
        rr_d     = (i == NumReq - 1) ? '0 : PtrW'(i + 1);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
        rr_d     = (i == NumReq - 1) ? '0 : PtrW'(i + 1);
      end
    end
    if (!advance_i) rr_d = rr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/banked_multi_port_memory.sv
// Multi-port scratchpad over low-order-interleaved banks, one round-robin arbiter per
// bank, registered read data returned exactly one cycle after the handshake.
module banked_multi_port_memory
  import banked_mem_pkg::*;
#(
  parameter int NumPorts  = DefNumPorts,
  parameter int NumBanks  = DefNumBanks,
  parameter int DataWidth = DefDataWidth,
  parameter int DataDepth = DefDataDepth,
  parameter int AddrWidth = safe_clog2(DataDepth)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_valid_i,
  output logic [NumPorts-1:0]                 req_ready_o,
  input  logic [NumPorts-1:0]                 req_we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  req_addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  req_wdata_i,
  output logic [NumPorts-1:0]                 rsp_valid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rsp_rdata_o
);

  localparam int BankBits = $clog2(NumBanks);
  localparam int BankIdxW = safe_clog2(NumBanks);
  localparam int RowDepth = DataDepth / NumBanks;
  localparam int RowWidth = safe_clog2(RowDepth);
  localparam int PortW    = safe_clog2(NumPorts);

  logic [NumPorts-1:0][BankIdxW-1:0]  port_bank;
  logic [NumPorts-1:0][RowWidth-1:0]  port_row;
  logic [NumBanks-1:0][NumPorts-1:0]  bank_req, bank_gnt;
  logic [NumBanks-1:0][DataWidth-1:0] bank_rdata;
  logic [NumPorts-1:0]                port_gnt;
  logic [NumPorts-1:0]                rsp_valid_q, rsp_valid_d;
  logic [NumPorts-1:0][DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      port_bank[p] = (NumBanks == 1) ? '0 : BankIdxW'(req_addr_i[p]);
      port_row[p]  = RowWidth'(req_addr_i[p] >> BankBits);
    end
  end

  // Requests are masked during reset so nothing is granted and no write can land.
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[b][p] = req_valid_i[p] && !rst_i && (port_bank[p] == BankIdxW'(b));
      end
    end
  end

  always_comb begin
    port_gnt = '0;
    for (int b = 0; b < NumBanks; b++) port_gnt = port_gnt | bank_gnt[b];
  end

  assign req_ready_o = port_gnt;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [PortW-1:0]     sel;
    logic                 fire;
    logic [RowWidth-1:0]  row;
    logic [DataWidth-1:0] mem [RowDepth];

    // A granted request always transfers, so the pointer advances on every grant.
    rr_arbiter #(.NumReq(NumPorts)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (bank_req[b]),
      .advance_i (1'b1),
      .gnt_o     (bank_gnt[b])
    );

    always_comb begin
      sel = '0;
      for (int p = 0; p < NumPorts; p++) begin
        if (bank_gnt[b][p]) sel = PortW'(p);
      end
      fire = |bank_gnt[b];
      row  = port_row[sel];
    end

    // NOTE: the storage array has no reset branch: contents survive rst_i, and a
    // reset on a RAM would prevent it from mapping onto block memory.
    always_ff @(posedge clk_i) begin
      if (fire && req_we_i[sel]) mem[row] <= req_wdata_i[sel];
    end

    assign bank_rdata[b] = mem[row];
  end

  // Data words are treated as raw bits; signedness only matters to the requesters.
  always_comb begin
    rsp_valid_d = port_gnt & ~req_we_i;
    rsp_rdata_d = rsp_rdata_q;
    for (int p = 0; p < NumPorts; p++) begin
      if (rsp_valid_d[p]) rsp_rdata_d[p] = bank_rdata[port_bank[p]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_banked_multi_port_memory.sv
// Directed bench for banked_multi_port_memory: reset, write/read, bank conflicts,
// signed data and reset in the middle of arbitration.
module tb_banked_multi_port_memory;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [3:0]       req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [3:0][11:0] req_addr_i;
  logic [3:0][7:0]  req_wdata_i, rsp_rdata_o;

  int n_vec = 0;
  int n_err = 0;

  banked_multi_port_memory dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] p, input logic v, input logic we,
                         input logic [11:0] a, input logic [7:0] d);
    req_valid_i[p] = v;
    req_we_i[p]    = we;
    req_addr_i[p]  = a;
    req_wdata_i[p] = d;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [3:0] exp_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] exp_dat  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  logic [1:0] exp_port [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b0;
    req_valid_i = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;

    // Reset with every port requesting writes to bank 0 (addrs 0,4,8,12).
    #1 rst_i = 1'b1;
    for (int p = 0; p < 4; p++) set_req(2'(p), 1'b1, 1'b1, 12'(p * 4), 8'(16 + p));
    #1;
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("rst_rdata", 32'(rsp_rdata_o), 32'h0);
    tick();
    tick();
    check("rst_ready_held", 32'(req_ready_o), 32'h0);
    rst_i = 1'b0;
    #1;
    // Bank 0 grants in port order; each port drops after its write lands.
    for (int k = 0; k < 4; k++) begin
      check("init_wr_order", 32'(req_ready_o), 32'(exp_gnt[k]));
      tick();
      req_valid_i = req_valid_i & ~exp_gnt[k];
      #1;
    end
    req_valid_i = '0;

    // Write then read back on port 0.
    set_req(2'd0, 1'b1, 1'b1, 12'h005, 8'h5A);
    #1 check("wr_ready", 32'(req_ready_o), 32'h1);
    tick();
    check("wr_no_rsp", 32'(rsp_valid_o), 32'h0);
    set_req(2'd0, 1'b1, 1'b0, 12'h005, 8'h00);
    #1 check("rd_ready", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = '0;
    check("rd_rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("rd_rdata", 32'(rsp_rdata_o[0]), 32'h5A);

    // All ports read bank 0; p0 re-requests and is served again after p3.
    for (int p = 0; p < 4; p++) set_req(2'(p), 1'b1, 1'b0, 12'(p * 4), 8'h00);
    for (int k = 0; k < 5; k++) begin
      #1 check("conflict_ready", 32'(req_ready_o), 32'(exp_gnt[k]));
      tick();
      check("conflict_rsp_valid", 32'(rsp_valid_o), 32'(exp_gnt[k]));
      check("conflict_rdata", 32'(rsp_rdata_o[exp_port[k]]), 32'(exp_dat[k]));
      req_valid_i = req_valid_i & ~(exp_gnt[k] & 4'b1110);
    end
    req_valid_i = '0;

    // Distinct banks: three parallel writes, then four parallel reads.
    for (int p = 1; p < 4; p++) set_req(2'(p), 1'b1, 1'b1, 12'(p), 8'(32 + p));
    #1 check("par_wr_ready", 32'(req_ready_o), 32'hE);
    tick();
    for (int p = 0; p < 4; p++) set_req(2'(p), 1'b1, 1'b0, 12'(p), 8'h00);
    #1 check("par_rd_ready", 32'(req_ready_o), 32'hF);
    tick();
    req_valid_i = '0;
    check("par_rsp_valid", 32'(rsp_valid_o), 32'hF);
    check("par_rdata", 32'(rsp_rdata_o), 32'h23222110);
    tick();
    check("rsp_valid_pulse", 32'(rsp_valid_o), 32'h0);
    check("rdata_hold", 32'(rsp_rdata_o[3]), 32'h23);

    // Signed extreme at the top address.
    set_req(2'd2, 1'b1, 1'b1, 12'hFFF, 8'h80);
    #1 check("signed_wr_ready", 32'(req_ready_o), 32'h4);
    tick();
    set_req(2'd2, 1'b1, 1'b0, 12'hFFF, 8'h00);
    tick();
    req_valid_i = '0;
    check("signed_rsp_valid", 32'(rsp_valid_o), 32'h4);
    check("signed_bits", 32'(rsp_rdata_o[2]), 32'h80);
    check("signed_value", 32'(int'($signed(rsp_rdata_o[2]))), 32'(-128));

    // Reset while p0/p2/p3 still wait on bank 0 (pointer currently at p1).
    for (int p = 0; p < 4; p++) set_req(2'(p), 1'b1, 1'b0, 12'(p * 4), 8'h00);
    #1 check("midop_ready", 32'(req_ready_o), 32'h2);
    tick();
    check("midop_rsp_valid", 32'(rsp_valid_o), 32'h2);
    req_valid_i[1] = 1'b0;
    rst_i = 1'b1;
    #1;
    check("midop_rst_valid", 32'(rsp_valid_o), 32'h0);
    check("midop_rst_rdata", 32'(rsp_rdata_o), 32'h0);
    check("midop_rst_ready", 32'(req_ready_o), 32'h0);
    tick();
    rst_i = 1'b0;
    #1 check("restart_order", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = '0;
    check("restart_rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("restart_rdata", 32'(rsp_rdata_o[0]), 32'h10);
    set_req(2'd0, 1'b1, 1'b0, 12'h005, 8'h00);
    tick();
    req_valid_i = '0;
    check("preserved_valid", 32'(rsp_valid_o), 32'h1);
    check("preserved_rdata", 32'(rsp_rdata_o[0]), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
